// File: rtl/obj_centroid_if.sv
// Video-side bundle for obj_centroid: the mask/timing stream coming in and
// the published centroid going out to the overlay renderer.
interface obj_centroid_if;
  logic        Binary_in;
  logic [11:0] VtcHCnt;
  logic [11:0] VtcVCnt;
  logic [11:0] center_h;
  logic [11:0] center_v;
  logic        obj_found;
  logic        center_valid;

  // Source side: drives the pixel stream, observes the result.
  modport master (
    output Binary_in, VtcHCnt, VtcVCnt,
    input  center_h, center_v, obj_found, center_valid
  );

  // Centroid block side.
  modport slave (
    input  Binary_in, VtcHCnt, VtcVCnt,
    output center_h, center_v, obj_found, center_valid
  );
endinterface

// File: rtl/obj_centroid.sv
// Frame centroid of a binary mask. Pixel-rate accumulation of count and
// coordinate sums, snapshot at frame end, then two serial restoring divides
// (horizontal, vertical) during blanking before publishing the centre.
module obj_centroid #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16
) (
  input logic           PClk,
  input logic           Rst,
  obj_centroid_if.slave vid
);

  localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM   = 12'(V_ACTIVE);
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);
  localparam logic [4:0]  LAST_IT = 5'd27;
  localparam logic [11:0] NO_OBJ  = 12'hFFF;

  typedef enum logic [1:0] {IDLE, DIV_H, DIV_V, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [27:0] sum_h_q, sum_h_d;
  logic [27:0] sum_v_q, sum_v_d;
  logic [18:0] snap_cnt_q, snap_cnt_d;
  logic [27:0] snap_sum_h_q, snap_sum_h_d;
  logic [27:0] snap_sum_v_q, snap_sum_v_d;
  logic [18:0] rem_q, rem_d;
  logic [27:0] quo_q, quo_d;
  logic [4:0]  iter_q, iter_d;
  logic [11:0] q_h_q, q_h_d;
  logic        obj_q, obj_d;
  logic [11:0] center_h_q, center_h_d;
  logic [11:0] center_v_q, center_v_d;
  logic        found_q, found_d;
  logic        valid_q, valid_d;

  logic        pix_ok;
  logic        frame_end;
  logic [19:0] rem_sh;
  logic [19:0] rem_diff;
  logic        rem_ge;
  logic [18:0] rem_nx;
  logic [27:0] quo_nx;

  assign pix_ok    = vid.Binary_in && (vid.VtcHCnt < H_LIM) && (vid.VtcVCnt < V_LIM);
  assign frame_end = (vid.VtcVCnt == V_LIM) && (vid.VtcHCnt == 12'd0);

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, shift the quotient bit in.
  assign rem_sh   = {rem_q, quo_q[27]};
  assign rem_diff = rem_sh - {1'b0, snap_cnt_q};
  assign rem_ge   = rem_sh >= {1'b0, snap_cnt_q};
  assign rem_nx   = rem_ge ? rem_diff[18:0] : rem_sh[18:0];
  assign quo_nx   = {quo_q[26:0], rem_ge};

  // Accumulators: clear on frame end, otherwise add each qualifying pixel.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    cnt_d   = cnt_q;
    sum_h_d = sum_h_q;
    sum_v_d = sum_v_q;
    if (frame_end) begin
      cnt_d   = '0;
      sum_h_d = '0;
      sum_v_d = '0;
    end else if (pix_ok) begin
      cnt_d   = cnt_q + 19'd1;
      sum_h_d = sum_h_q + 28'(vid.VtcHCnt);
      sum_v_d = sum_v_q + 28'(vid.VtcVCnt);
    end
  end

  // Control FSM: snapshot/launch on frame end, two divides, then publish.
  always_comb begin
    state_d      = state_q;
    snap_cnt_d   = snap_cnt_q;
    snap_sum_h_d = snap_sum_h_q;
    snap_sum_v_d = snap_sum_v_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    iter_d       = iter_q;
    q_h_d        = q_h_q;
    obj_d        = obj_q;
    center_h_d   = center_h_q;
    center_v_d   = center_v_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_end) begin
          snap_cnt_d   = cnt_q;
          snap_sum_h_d = sum_h_q;
          snap_sum_v_d = sum_v_q;
          if (cnt_q < MIN_CNT) begin
            obj_d   = 1'b0;
            state_d = UPDATE;
          end else begin
            obj_d   = 1'b1;
            rem_d   = '0;
            quo_d   = sum_h_q;
            iter_d  = '0;
            state_d = DIV_H;
          end
        end
      end
      DIV_H: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_IT) begin
          q_h_d   = quo_nx[11:0];
          rem_d   = '0;
          quo_d   = snap_sum_v_q;
          iter_d  = '0;
          state_d = DIV_V;
        end
      end
      DIV_V: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_IT) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        valid_d = 1'b1;
        if (obj_q) begin
          center_h_d = q_h_q;
          center_v_d = quo_q[11:0];
          found_d    = 1'b1;
        end else begin
          center_h_d = NO_OBJ;
          center_v_d = NO_OBJ;
          found_d    = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also aborts any divide in progress.
  always_ff @(posedge PClk or posedge Rst) begin
    if (Rst) begin
      // NOTE: the datapath is reset too, so an aborted divide leaves no stale
      // operands and the first frame after reset starts from clean sums.
      state_q      <= IDLE;
      cnt_q        <= '0;
      sum_h_q      <= '0;
      sum_v_q      <= '0;
      snap_cnt_q   <= '0;
      snap_sum_h_q <= '0;
      snap_sum_v_q <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      iter_q       <= '0;
      q_h_q        <= '0;
      obj_q        <= 1'b0;
      center_h_q   <= NO_OBJ;
      center_v_q   <= NO_OBJ;
      found_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sum_h_q      <= sum_h_d;
      sum_v_q      <= sum_v_d;
      snap_cnt_q   <= snap_cnt_d;
      snap_sum_h_q <= snap_sum_h_d;
      snap_sum_v_q <= snap_sum_v_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      iter_q       <= iter_d;
      q_h_q        <= q_h_d;
      obj_q        <= obj_d;
      center_h_q   <= center_h_d;
      center_v_q   <= center_v_d;
      found_q      <= found_d;
      valid_q      <= valid_d;
    end
  end

  assign vid.center_h     = center_h_q;
  assign vid.center_v     = center_v_q;
  assign vid.obj_found    = found_q;
  assign vid.center_valid = valid_q;

endmodule

// File: tb/tb_obj_centroid.sv
// Directed bench for obj_centroid. Two 640x480 instances share one pixel
// stream (MIN_PIXELS 1 and 16); a small 64x48 instance covers a fully set frame.
module tb_obj_centroid;

  logic        PClk = 1'b0;
  logic        Rst;
  logic        bin;
  logic [11:0] hcnt, vcnt;
  logic        c_bin;
  logic [11:0] c_h, c_v;

  int checks   = 0;
  int failures = 0;
  int lat_a, lat_b, lat_c;
  int n_a, n_b, n_c;

  always #5 PClk = ~PClk;

  obj_centroid_if if_a ();
  obj_centroid_if if_b ();
  obj_centroid_if if_c ();

  assign if_a.Binary_in = bin;
  assign if_a.VtcHCnt   = hcnt;
  assign if_a.VtcVCnt   = vcnt;
  assign if_b.Binary_in = bin;
  assign if_b.VtcHCnt   = hcnt;
  assign if_b.VtcVCnt   = vcnt;
  assign if_c.Binary_in = c_bin;
  assign if_c.VtcHCnt   = c_h;
  assign if_c.VtcVCnt   = c_v;

  obj_centroid #(.H_ACTIVE(640), .V_ACTIVE(480), .MIN_PIXELS(1))
    dut_a (.PClk(PClk), .Rst(Rst), .vid(if_a));
  obj_centroid #(.H_ACTIVE(640), .V_ACTIVE(480), .MIN_PIXELS(16))
    dut_b (.PClk(PClk), .Rst(Rst), .vid(if_b));
  obj_centroid #(.H_ACTIVE(64), .V_ACTIVE(48), .MIN_PIXELS(16))
    dut_c (.PClk(PClk), .Rst(Rst), .vid(if_c));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PClk);
    #1;
  endtask

  task automatic px(input int h, input int v);
    bin  = 1'b1;
    hcnt = 12'(h);
    vcnt = 12'(v);
    step();
    bin  = 1'b0;
    hcnt = 12'd0;
    vcnt = 12'd0;
  endtask

  task automatic block(input int h0, input int v0, input int n);
    for (int v = v0; v < v0 + n; v++)
      for (int h = h0; h < h0 + n; h++)
        px(h, v);
  endtask

  // Present frame_end to the shared stream; returns one step after E0.
  task automatic fe();
    bin  = 1'b0;
    hcnt = 12'd0;
    vcnt = 12'd480;
    step();
    vcnt = 12'd0;
  endtask

  // Observe a bounded window, recording first-pulse latency and pulse count.
  task automatic watch(input int cycles);
    lat_a = 0; lat_b = 0; lat_c = 0;
    n_a = 0; n_b = 0; n_c = 0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (if_a.center_valid) begin n_a++; if (lat_a == 0) lat_a = k; end
      if (if_b.center_valid) begin n_b++; if (lat_b == 0) lat_b = k; end
      if (if_c.center_valid) begin n_c++; if (lat_c == 0) lat_c = k; end
    end
  endtask

  task automatic expect_a(input string tag, input int h, input int v, input int f);
    check({tag, "_a_h"}, int'(if_a.center_h), h);
    check({tag, "_a_v"}, int'(if_a.center_v), v);
    check({tag, "_a_found"}, int'(if_a.obj_found), f);
  endtask

  task automatic expect_b(input string tag, input int h, input int v, input int f);
    check({tag, "_b_h"}, int'(if_b.center_h), h);
    check({tag, "_b_v"}, int'(if_b.center_v), v);
    check({tag, "_b_found"}, int'(if_b.obj_found), f);
  endtask

  initial begin
    Rst = 1'b1; bin = 1'b0; hcnt = '0; vcnt = '0;
    c_bin = 1'b0; c_h = '0; c_v = '0;
    step(); step();
    expect_a("reset", 4095, 4095, 0);
    check("reset_a_valid", int'(if_a.center_valid), 0);
    check("reset_c_h", int'(if_c.center_h), 4095);
    Rst = 1'b0;
    step();

    // Single pixel: A divides (57 cycles), B sees too few pixels (1 cycle).
    px(100, 50);
    fe();
    watch(70);
    check("single_a_lat", lat_a, 57);
    check("single_a_cnt", n_a, 1);
    expect_a("single", 100, 50, 1);
    check("single_b_lat", lat_b, 1);
    expect_b("single", 4095, 4095, 0);

    // 10x10 block: 304.5 / 204.5 truncate.
    block(300, 200, 10);
    fe();
    watch(70);
    check("block_a_lat", lat_a, 57);
    expect_a("block", 304, 204, 1);
    check("block_b_lat", lat_b, 57);
    expect_b("block", 304, 204, 1);

    // 15 pixels on row 10, columns 0..14: below B's threshold only.
    for (int h = 0; h < 15; h++) px(h, 10);
    fe();
    watch(70);
    expect_a("fifteen", 7, 10, 1);
    check("fifteen_b_lat", lat_b, 1);
    check("fifteen_b_cnt", n_b, 1);
    expect_b("fifteen", 4095, 4095, 0);

    // Empty frame: neither instance finds an object.
    fe();
    watch(70);
    check("empty_a_lat", lat_a, 1);
    expect_a("empty", 4095, 4095, 0);
    check("empty_b_lat", lat_b, 1);
    expect_b("empty", 4095, 4095, 0);

    // Back-to-back objects with no carry-over.
    block(98, 98, 5);
    fe();
    watch(70);
    expect_a("b2b1", 100, 100, 1);
    expect_b("b2b1", 100, 100, 1);
    block(498, 398, 5);
    fe();
    watch(70);
    expect_a("b2b2", 500, 400, 1);
    expect_b("b2b2", 500, 400, 1);

    // Overrun: second frame_end mid-divide is dropped but still clears sums.
    block(98, 98, 5);
    fe();
    repeat (10) step();
    px(600, 400); px(601, 400); px(602, 400);
    fe();
    watch(70);
    check("overrun_a_cnt", n_a, 1);
    check("overrun_b_cnt", n_b, 1);
    expect_a("overrun", 100, 100, 1);
    block(498, 398, 5);
    fe();
    watch(70);
    check("after_overrun_a_lat", lat_a, 57);
    expect_a("after_overrun", 500, 400, 1);

    // Reset at E20 inside DIV_H: no pulse, outputs to no-object.
    block(300, 200, 10);
    fe();
    repeat (19) step();
    Rst = 1'b1;
    step(); step();
    expect_a("midrst", 4095, 4095, 0);
    expect_b("midrst", 4095, 4095, 0);
    Rst = 1'b0;
    watch(70);
    check("midrst_a_cnt", n_a, 0);
    check("midrst_b_cnt", n_b, 0);
    px(100, 50);
    fe();
    watch(70);
    check("postrst_a_lat", lat_a, 57);
    expect_a("postrst", 100, 50, 1);

    // Fully set 64x48 frame on the small instance: 31.5 / 23.5 truncate.
    for (int v = 0; v < 48; v++)
      for (int h = 0; h < 64; h++) begin
        c_bin = 1'b1; c_h = 12'(h); c_v = 12'(v);
        step();
      end
    c_bin = 1'b0; c_h = 12'd0; c_v = 12'd48;
    step();
    c_v = 12'd0;
    watch(70);
    check("full_c_lat", lat_c, 57);
    check("full_c_cnt", n_c, 1);
    check("full_c_h", int'(if_c.center_h), 31);
    check("full_c_v", int'(if_c.center_v), 23);
    check("full_c_found", int'(if_c.obj_found), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
